// File: rtl/lc3_trace_buffer_if.sv
// Trace buffer port bundle.
//   master: trace source / host side (drives core taps and pop request)
//   slave : trace buffer side (returns popped records and status flags)
// Signals: enable, cur_state, pc_in, ir_in, ld_reg, bus_in, mem_we, mar_in,
//          mdr_in, rd_en (to buffer); rd_valid, rd_data, count, empty, full,
//          overflow, halted (from buffer).
interface lc3_trace_buffer_if #(
  parameter int DATA_W  = 16,
  parameter int STATE_W = 6,
  parameter int DEPTH   = 64
);
  localparam int REC_W = 5 * DATA_W + 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               enable;
  logic [STATE_W-1:0] cur_state;
  logic [DATA_W-1:0]  pc_in;
  logic [DATA_W-1:0]  ir_in;
  logic               ld_reg;
  logic [DATA_W-1:0]  bus_in;
  logic               mem_we;
  logic [DATA_W-1:0]  mar_in;
  logic [DATA_W-1:0]  mdr_in;
  logic               rd_en;
  logic               rd_valid;
  logic [REC_W-1:0]   rd_data;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               overflow;
  logic               halted;

  modport master (
    output enable, cur_state, pc_in, ir_in, ld_reg, bus_in, mem_we, mar_in, mdr_in, rd_en,
    input  rd_valid, rd_data, count, empty, full, overflow, halted
  );

  modport slave (
    input  enable, cur_state, pc_in, ir_in, ld_reg, bus_in, mem_we, mar_in, mdr_in, rd_en,
    output rd_valid, rd_data, count, empty, full, overflow, halted
  );
endinterface

// File: rtl/lc3_trace_buffer.sv
// LC-3 instruction trace recorder.
// Detects instruction boundaries (entry into the fetch state), accumulates the
// register/memory writes of the instruction in flight, and on the next
// boundary retires one record {pc, ir, reg_wr, reg_data, mem_wr, mem_addr,
// mem_data} into a circular buffer drained through a 1-cycle-latency pop port.
// Ports: clk, reset (sync, active-high), trc (lc3_trace_buffer_if.slave).
module lc3_trace_buffer #(
  parameter int                 DATA_W      = 16,
  parameter int                 STATE_W     = 6,
  parameter logic [STATE_W-1:0] FETCH_STATE = 6'd18,
  parameter int                 DEPTH       = 64,
  parameter logic [DATA_W-1:0]  HALT_WORD   = 16'hFFFF,
  parameter int                 WRAP_MODE   = 0
) (
  input logic               clk,
  input logic               reset,
  lc3_trace_buffer_if.slave trc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 5 * DATA_W + 2;

  logic               prev_fetch_q, prev_fetch_d;
  logic               pending_q, pending_d;
  logic               halted_q, halted_d;
  logic [DATA_W-1:0]  pc_lat_q, pc_lat_d;
  logic               acc_reg_wr_q, acc_reg_wr_d;
  logic [DATA_W-1:0]  acc_reg_data_q, acc_reg_data_d;
  logic               acc_mem_wr_q, acc_mem_wr_d;
  logic [DATA_W-1:0]  acc_mem_addr_q, acc_mem_addr_d;
  logic [DATA_W-1:0]  acc_mem_data_q, acc_mem_data_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q, rd_valid_d;
  logic [REC_W-1:0]   rd_data_q, rd_data_d;
  logic [REC_W-1:0]   mem_q [DEPTH];

  logic               fetch_entry, retire, is_full, is_empty, pop;
  logic               push_write, overwrite;
  logic [REC_W-1:0]   record;

  always_comb begin
    fetch_entry = (trc.cur_state == FETCH_STATE) && !prev_fetch_q;
    retire      = fetch_entry && trc.enable && !halted_q && pending_q && (trc.ir_in != '0);
    record      = {pc_lat_q, trc.ir_in, acc_reg_wr_q, acc_reg_data_q,
                   acc_mem_wr_q, acc_mem_addr_q, acc_mem_data_q};
    is_full     = (count_q == CNT_W'(DEPTH));
    is_empty    = (count_q == '0);
    pop         = trc.rd_en && !is_empty;
    // A full buffer still accepts a record when a pop frees a slot this cycle.
    push_write  = retire && (!is_full || pop || (WRAP_MODE != 0));
    overwrite   = retire && is_full && !pop && (WRAP_MODE != 0);
  end

  always_comb begin
    prev_fetch_d   = (trc.cur_state == FETCH_STATE);
    pending_d      = pending_q;
    halted_d       = halted_q;
    pc_lat_d       = pc_lat_q;
    acc_reg_wr_d   = acc_reg_wr_q;
    acc_reg_data_d = acc_reg_data_q;
    acc_mem_wr_d   = acc_mem_wr_q;
    acc_mem_addr_d = acc_mem_addr_q;
    acc_mem_data_d = acc_mem_data_q;

    if (trc.enable) begin
      // Clear before load: strobes in the boundary cycle belong to the new instruction.
      if (fetch_entry && !halted_q) begin
        pc_lat_d       = trc.pc_in;
        pending_d      = 1'b1;
        acc_reg_wr_d   = 1'b0;
        acc_reg_data_d = '0;
        acc_mem_wr_d   = 1'b0;
        acc_mem_addr_d = '0;
        acc_mem_data_d = '0;
      end
      if (trc.ld_reg) begin
        acc_reg_wr_d   = 1'b1;
        acc_reg_data_d = trc.bus_in;
      end
      if (trc.mem_we) begin
        acc_mem_wr_d   = 1'b1;
        acc_mem_addr_d = trc.mar_in;
        acc_mem_data_d = trc.mdr_in;
      end
    end else begin
      pending_d = 1'b0;
    end

    if (retire && (trc.ir_in == HALT_WORD)) halted_d = 1'b1;

    wr_ptr_d = push_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = (pop || overwrite) ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push_write && !overwrite && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_write)               count_d = count_q - 1'b1;

    overflow_d = overflow_q || (retire && is_full && !pop);
    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_fetch_q   <= 1'b0;
      pending_q      <= 1'b0;
      halted_q       <= 1'b0;
      pc_lat_q       <= '0;
      acc_reg_wr_q   <= 1'b0;
      acc_reg_data_q <= '0;
      acc_mem_wr_q   <= 1'b0;
      acc_mem_addr_q <= '0;
      acc_mem_data_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      prev_fetch_q   <= prev_fetch_d;
      pending_q      <= pending_d;
      halted_q       <= halted_d;
      pc_lat_q       <= pc_lat_d;
      acc_reg_wr_q   <= acc_reg_wr_d;
      acc_reg_data_q <= acc_reg_data_d;
      acc_mem_wr_q   <= acc_mem_wr_d;
      acc_mem_addr_q <= acc_mem_addr_d;
      acc_mem_data_q <= acc_mem_data_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push_write) mem_q[wr_ptr_q] <= record;
  end

  assign trc.rd_valid = rd_valid_q;
  assign trc.rd_data  = rd_data_q;
  assign trc.count    = count_q;
  assign trc.empty    = is_empty;
  assign trc.full     = is_full;
  assign trc.overflow = overflow_q;
  assign trc.halted   = halted_q;
endmodule

// File: tb/tb_lc3_trace_buffer.sv
// Bench for lc3_trace_buffer: three instances (DEPTH 64/wrap 0, DEPTH 4/wrap 0,
// DEPTH 4/wrap 1) share one stimulus stream; a queue-based model predicts
// every output each cycle, and directed literals pin the model.
module tb_lc3_trace_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [5:0]  cur_state;
  logic [15:0] pc_in, ir_in, bus_in, mar_in, mdr_in;
  logic        ld_reg, mem_we, rd_en;

  int errors = 0;
  int checks = 0;
  logic [15:0] prev_ir;

  always #5 clk = ~clk;

  lc3_trace_buffer_if #(.DATA_W(16), .STATE_W(6), .DEPTH(64)) bus0 ();
  lc3_trace_buffer_if #(.DATA_W(16), .STATE_W(6), .DEPTH(4))  bus1 ();
  lc3_trace_buffer_if #(.DATA_W(16), .STATE_W(6), .DEPTH(4))  bus2 ();

  assign bus0.enable = enable; assign bus1.enable = enable; assign bus2.enable = enable;
  assign bus0.cur_state = cur_state; assign bus1.cur_state = cur_state; assign bus2.cur_state = cur_state;
  assign bus0.pc_in = pc_in; assign bus1.pc_in = pc_in; assign bus2.pc_in = pc_in;
  assign bus0.ir_in = ir_in; assign bus1.ir_in = ir_in; assign bus2.ir_in = ir_in;
  assign bus0.ld_reg = ld_reg; assign bus1.ld_reg = ld_reg; assign bus2.ld_reg = ld_reg;
  assign bus0.bus_in = bus_in; assign bus1.bus_in = bus_in; assign bus2.bus_in = bus_in;
  assign bus0.mem_we = mem_we; assign bus1.mem_we = mem_we; assign bus2.mem_we = mem_we;
  assign bus0.mar_in = mar_in; assign bus1.mar_in = mar_in; assign bus2.mar_in = mar_in;
  assign bus0.mdr_in = mdr_in; assign bus1.mdr_in = mdr_in; assign bus2.mdr_in = mdr_in;
  assign bus0.rd_en = rd_en; assign bus1.rd_en = rd_en; assign bus2.rd_en = rd_en;

  lc3_trace_buffer #(.DATA_W(16), .STATE_W(6), .FETCH_STATE(6'd18), .DEPTH(64),
                     .HALT_WORD(16'hFFFF), .WRAP_MODE(0)) u0 (.clk(clk), .reset(reset), .trc(bus0));
  lc3_trace_buffer #(.DATA_W(16), .STATE_W(6), .FETCH_STATE(6'd18), .DEPTH(4),
                     .HALT_WORD(16'hFFFF), .WRAP_MODE(0)) u1 (.clk(clk), .reset(reset), .trc(bus1));
  lc3_trace_buffer #(.DATA_W(16), .STATE_W(6), .FETCH_STATE(6'd18), .DEPTH(4),
                     .HALT_WORD(16'hFFFF), .WRAP_MODE(1)) u2 (.clk(clk), .reset(reset), .trc(bus2));

  // DUT outputs gathered per instance
  logic        a_rv[3], a_empty[3], a_full[3], a_ovf[3], a_halt[3];
  logic [81:0] a_data[3];
  logic [6:0]  a_cnt[3];
  assign a_rv[0] = bus0.rd_valid; assign a_rv[1] = bus1.rd_valid; assign a_rv[2] = bus2.rd_valid;
  assign a_data[0] = bus0.rd_data; assign a_data[1] = bus1.rd_data; assign a_data[2] = bus2.rd_data;
  assign a_cnt[0] = bus0.count; assign a_cnt[1] = {4'b0, bus1.count}; assign a_cnt[2] = {4'b0, bus2.count};
  assign a_empty[0] = bus0.empty; assign a_empty[1] = bus1.empty; assign a_empty[2] = bus2.empty;
  assign a_full[0] = bus0.full; assign a_full[1] = bus1.full; assign a_full[2] = bus2.full;
  assign a_ovf[0] = bus0.overflow; assign a_ovf[1] = bus1.overflow; assign a_ovf[2] = bus2.overflow;
  assign a_halt[0] = bus0.halted; assign a_halt[1] = bus1.halted; assign a_halt[2] = bus2.halted;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          dep [3] = '{64, 4, 4};
  bit          wrp [3] = '{0, 0, 1};
  logic [81:0] mq [3][$];
  logic [81:0] m_data [3];
  bit          m_rv [3];
  bit          m_ovf [3];
  bit          m_prev, m_pending, m_halted, m_rw, m_mw;
  logic [15:0] m_pc, m_rd, m_ma, m_md;
  bit          started = 0;

  always @(posedge clk) begin
    bit fe, ret;
    logic [81:0] rec;
    started = 1;
    if (reset) begin
      m_prev = 0; m_pending = 0; m_halted = 0; m_rw = 0; m_mw = 0;
      m_pc = '0; m_rd = '0; m_ma = '0; m_md = '0;
      for (int i = 0; i < 3; i++) begin
        mq[i].delete(); m_data[i] = '0; m_rv[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      fe  = (cur_state == 6'd18) && !m_prev;
      m_prev = (cur_state == 6'd18);
      ret = fe && enable && !m_halted && m_pending && (ir_in != 16'h0);
      rec = {m_pc, ir_in, m_rw, m_rd, m_mw, m_ma, m_md};
      for (int i = 0; i < 3; i++) begin
        m_rv[i] = 0;
        if (rd_en && mq[i].size() != 0) begin
          m_data[i] = mq[i].pop_front();
          m_rv[i] = 1;
        end
        if (ret) begin
          if (mq[i].size() < dep[i]) mq[i].push_back(rec);
          else begin
            m_ovf[i] = 1;
            if (wrp[i]) begin
              void'(mq[i].pop_front());
              mq[i].push_back(rec);
            end
          end
        end
      end
      if (enable) begin
        if (fe && !m_halted) begin
          m_pc = pc_in; m_pending = 1;
          m_rw = 0; m_rd = '0; m_mw = 0; m_ma = '0; m_md = '0;
        end
        if (ld_reg) begin m_rw = 1; m_rd = bus_in; end
        if (mem_we) begin m_mw = 1; m_ma = mar_in; m_md = mdr_in; end
      end else begin
        m_pending = 0;
      end
      if (ret && ir_in == 16'hFFFF) m_halted = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d rd_valid", i), 128'(a_rv[i]), 128'(m_rv[i]));
        chk($sformatf("u%0d rd_data", i), 128'(a_data[i]), 128'(m_data[i]));
        chk($sformatf("u%0d count", i), 128'(a_cnt[i]), 128'(mq[i].size()));
        chk($sformatf("u%0d empty", i), 128'(a_empty[i]), 128'(mq[i].size() == 0));
        chk($sformatf("u%0d full", i), 128'(a_full[i]), 128'(mq[i].size() == dep[i]));
        chk($sformatf("u%0d overflow", i), 128'(a_ovf[i]), 128'(m_ovf[i]));
        chk($sformatf("u%0d halted", i), 128'(a_halt[i]), 128'(m_halted));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [5:0] st, input logic [15:0] pc, input logic [15:0] ir,
                     input logic ld, input logic [15:0] bus, input logic we,
                     input logic [15:0] mar, input logic [15:0] mdr);
    cur_state = st; pc_in = pc; ir_in = ir; ld_reg = ld; bus_in = bus;
    mem_we = we; mar_in = mar; mdr_in = mdr;
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [15:0] pc);
    cyc(6'd18, pc, prev_ir, 0, '0, 0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(6'd0, 16'h0, prev_ir, 0, '0, 0, '0, '0);
  endtask

  task automatic instr(input logic [15:0] pc, input logic [15:0] ir, input logic ld,
                       input logic [15:0] bus, input logic we, input logic [15:0] mar,
                       input logic [15:0] mdr);
    fetch(pc);
    cyc(6'd33, pc + 16'd1, prev_ir, 0, '0, 0, '0, '0);
    cyc(6'd35, pc + 16'd1, ir, 0, '0, 0, '0, '0);
    cyc(6'd1,  pc + 16'd1, ir, ld, bus, we, mar, mdr);
    prev_ir = ir;
  endtask

  task automatic do_reset();
    reset = 1; rd_en = 0;
    idle(2);
    reset = 0; prev_ir = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; enable = 1; rd_en = 0; prev_ir = '0;
    cur_state = '0; pc_in = '0; ir_in = '0; ld_reg = 0; bus_in = '0;
    mem_we = 0; mar_in = '0; mdr_in = '0;
    idle(2);
    chk("reset count", 128'(a_cnt[0]), 128'd0);
    chk("reset empty", 128'(a_empty[0]), 128'd1);
    chk("reset rd_data", 128'(a_data[0]), 128'd0);
    reset = 0;

    // ADD R1,R1,#1 then HALT
    instr(16'h3000, 16'h1261, 1, 16'h0001, 0, '0, '0);
    instr(16'h3001, 16'hFFFF, 0, '0, 0, '0, '0);
    fetch(16'h3002);
    idle(2);
    chk("halt flag", 128'(a_halt[0]), 128'd1);
    chk("halt count", 128'(a_cnt[0]), 128'd2);
    instr(16'h3002, 16'h1262, 1, 16'h0005, 0, '0, '0);
    fetch(16'h3003);
    chk("no capture after halt", 128'(a_cnt[0]), 128'd2);
    rd_en = 1; idle(1);
    chk("rec0", 128'(a_data[0]),
        128'({16'h3000, 16'h1261, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000}));
    idle(1); rd_en = 0;
    chk("rec1 ir", 128'(a_data[0][65:50]), 128'(16'hFFFF));
    chk("rec1 pc", 128'(a_data[0][81:66]), 128'(16'h3001));
    idle(1);
    chk("drained count", 128'(a_cnt[0]), 128'd0);
    chk("rd_data held", 128'(a_data[0][65:50]), 128'(16'hFFFF));

    // ST R1 -> x3010
    do_reset();
    instr(16'h3000, 16'h320F, 0, '0, 1, 16'h3010, 16'h00AB);
    fetch(16'h3001);
    rd_en = 1; idle(1); rd_en = 0;
    chk("st rec", 128'(a_data[0]),
        128'({16'h3000, 16'h320F, 1'b0, 16'h0000, 1'b1, 16'h3010, 16'h00AB}));

    // six retires, no pops
    do_reset();
    for (int k = 1; k <= 6; k++)
      instr(16'h3000 + 16'(k), 16'h1000 + 16'(k), 1, 16'(k), 0, '0, '0);
    fetch(16'h3007);
    idle(1);
    chk("w0 count", 128'(a_cnt[1]), 128'd4);
    chk("w0 full", 128'(a_full[1]), 128'd1);
    chk("w0 ovf", 128'(a_ovf[1]), 128'd1);
    chk("w1 ovf", 128'(a_ovf[2]), 128'd1);
    for (int k = 1; k <= 4; k++) begin
      rd_en = 1; idle(1);
      chk($sformatf("w0 pop%0d ir", k), 128'(a_data[1][65:50]), 128'(16'h1000 + 16'(k)));
      chk($sformatf("w1 pop%0d ir", k), 128'(a_data[2][65:50]), 128'(16'h1002 + 16'(k)));
    end
    rd_en = 0; idle(1);
    chk("w0 empty after pops", 128'(a_empty[1]), 128'd1);

    // full buffer, retire with same-cycle pop
    do_reset();
    for (int k = 1; k <= 5; k++)
      instr(16'h3000 + 16'(k), 16'h1000 + 16'(k), 0, '0, 0, '0, '0);
    chk("fill count", 128'(a_cnt[1]), 128'd4);
    rd_en = 1; fetch(16'h3006); rd_en = 0;
    chk("pp count", 128'(a_cnt[1]), 128'd4);
    chk("pp ovf", 128'(a_ovf[1]), 128'd0);
    chk("pp rd_valid", 128'(a_rv[1]), 128'd1);
    chk("pp data", 128'(a_data[1][65:50]), 128'(16'h1001));
    idle(1);

    // reset mid-instruction with three records stored
    do_reset();
    for (int k = 1; k <= 3; k++)
      instr(16'h3000 + 16'(k), 16'h1000 + 16'(k), 1, 16'h00F0, 0, '0, '0);
    fetch(16'h3004);
    cyc(6'd33, 16'h3005, prev_ir, 0, '0, 0, '0, '0);
    chk("pre-reset count", 128'(a_cnt[0]), 128'd3);
    reset = 1;
    cyc(6'd35, 16'h3005, 16'h1004, 0, '0, 0, '0, '0);
    reset = 0;
    chk("mid reset count", 128'(a_cnt[0]), 128'd0);
    chk("mid reset empty", 128'(a_empty[0]), 128'd1);
    chk("mid reset rd_valid", 128'(a_rv[0]), 128'd0);
    chk("mid reset halted", 128'(a_halt[0]), 128'd0);
    cyc(6'd1, 16'h3005, 16'h1004, 1, 16'h0077, 0, '0, '0);
    prev_ir = 16'h1004;
    fetch(16'h3005);
    chk("first boundary no record", 128'(a_cnt[0]), 128'd0);
    idle(1);

    // enable low: first boundary after re-enable only latches
    do_reset();
    enable = 0;
    instr(16'h4000, 16'h1261, 1, 16'h0002, 0, '0, '0);
    enable = 1;
    instr(16'h4001, 16'h1262, 1, 16'h0003, 0, '0, '0);
    chk("reenable no record", 128'(a_cnt[0]), 128'd0);
    fetch(16'h4002);
    chk("reenable one record", 128'(a_cnt[0]), 128'd1);
    rd_en = 1; idle(1); rd_en = 0;
    chk("reenable rec", 128'(a_data[0]),
        128'({16'h4001, 16'h1262, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000}));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc3_trace_buffer.md
Name: lc3_trace_buffer

Overview:
- Synthesisable on-chip instruction trace recorder for the lc3 core.
- Watches the controller state and the debug datapath taps, and emits one record per retired instruction: PC, IR, register-write and memory-write info.
- Stores records in a parametrised circular buffer that a host drains through a valid/ready-style pop port.
- Replaces file-based trace logging on hardware; trace data is field-for-field comparable with pennsim traces.

Parameters:
- DATA_W, 16, width of PC/IR/bus/address/data fields
- STATE_W, 6, controller state width
- FETCH_STATE, 6'd18, controller state code for fetch
- DEPTH, 64, buffer entries; power of two, >= 2
- HALT_WORD, 16'hFFFF, IR value that ends capture
- WRAP_MODE, 0, 0 = stop when full and drop new records; 1 = overwrite oldest

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  capture enable
- cur_state  in  STATE_W  controller current state
- pc_in  in  DATA_W  core PC
- ir_in  in  DATA_W  core instruction register
- ld_reg  in  1  register file write strobe
- bus_in  in  DATA_W  data bus (regfile write data)
- mem_we  in  1  memory write strobe
- mar_in  in  DATA_W  MAR
- mdr_in  in  DATA_W  MDR
- rd_en  in  1  pop request
- rd_valid  out  1  rd_data holds a popped record
- rd_data  out  5*DATA_W+2  {pc, ir, reg_wr, reg_data, mem_wr, mem_addr, mem_data}
- count  out  $clog2(DEPTH)+1  entries stored
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a record was dropped or overwritten
- halted  out  1  sticky: HALT_WORD retired

Behaviour:
- Reset: all outputs 0, including rd_data, count, flags and pointers. empty = 1. pending = 0. Accumulators cleared. Reset mid-operation discards all buffered records.
- Boundary detection:
  - fetch_entry is true in a cycle when cur_state == FETCH_STATE and the registered previous state != FETCH_STATE.
  - The first cycle after reset counts as previous state != FETCH_STATE.
- On fetch_entry, while enable = 1 and halted = 0:
  - If pending = 1 and ir_in != 0, retire a record: {pc_latched, ir_in, acc_reg_wr, acc_reg_data, acc_mem_wr, acc_mem_addr, acc_mem_data}.
  - Then pc_latched <= pc_in, pending <= 1, and all accumulators are cleared.
- Accumulators, every cycle:
  - ld_reg = 1 sets acc_reg_wr and loads acc_reg_data <= bus_in.
  - mem_we = 1 sets acc_mem_wr and loads acc_mem_addr <= mar_in, acc_mem_data <= mdr_in.
  - Last write wins.
  - Strobes sampled in the fetch_entry cycle belong to the new instruction: clear, then load.
- Halt: retiring a record whose ir == HALT_WORD writes that record, then sets halted. No further records are captured until reset.
- enable = 0: no retire and no accumulation. pending is cleared, so the first boundary after re-enable only latches the PC.
- Push, given a retire:
  - Not full: write at wr_ptr, wr_ptr++, count++.
  - Full with a same-cycle pop: accepted; count unchanged.
  - Full, no pop, WRAP_MODE = 0: record dropped, overflow <= 1.
  - Full, no pop, WRAP_MODE = 1: the oldest entry is overwritten, both pointers advance, count stays DEPTH, overflow <= 1.
- Pop:
  - rd_en with empty = 0: rd_data <= entry[rd_ptr], rd_valid = 1 the next cycle (1-cycle latency), rd_ptr++, count--.
  - rd_en while empty: ignored; rd_valid = 0.
  - rd_valid is a one-cycle pulse per pop. rd_data holds its value until the next pop.
- Pop and push in the same cycle on an empty buffer: the pop is ignored and the push is stored (no bypass).
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. count never exceeds DEPTH.

Test Plan:
- Program ADD R1,R1,#1 at x3000, then HALT_WORD; pop all: record 0 = {3000, 1261, 1, 0001, 0, 0000, 0000}, record 1 ir = FFFF, halted = 1, count returns to 0.
- ST R1 to x3010 with R1 = x00AB: record mem_wr = 1, mem_addr = 3010, mem_data = 00AB, reg_wr = 0.
- DEPTH = 4, WRAP_MODE = 0, six retires with no pops: count = 4, full = 1, overflow = 1; pops return records 1–4.
- DEPTH = 4, WRAP_MODE = 1, six retires: pops return records 3–6 in order, overflow = 1.
- Full buffer, retire and rd_en in the same cycle: count stays 4, no overflow, popped data = oldest entry.
- Assert reset mid-instruction with 3 records stored: next cycle count = 0, empty = 1, rd_valid = 0, halted = 0; the first post-reset boundary produces no record.
